mem_2_to_1_arbiter: RTL and testbench

- Upstream front-end for memory_2_to_1_wrapper. It accepts valid/ready read/write requests from two independent clients (client 0 and client 1).
- It arbitrates round-robin and issues at most one memory operation per cycle onto the wrapper's mem_0_*/mem_1_* port pair.
- It routes returned mem_dout back to the originating client with a per-client response valid.
- It guarantees the one-hot access invariant that the wrapper's fixed-priority muxing relies on.

---
 rtl/mem_2_to_1_arbiter_pkg.sv | 14 +
 rtl/rr_arbiter_2.sv | 33 +++
 rtl/mem_2_to_1_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_2_to_1_arbiter.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_2_to_1_arbiter_pkg.sv
// Shared types for the two-client memory arbiter.
// Client ids, response tags and default read latency.
package mem_2_to_1_arbiter_pkg;

  localparam int RD_LATENCY_DEF = 1;

  typedef logic client_id_t;

  typedef struct packed {
    logic       valid;
    client_id_t id;
  } rsp_tag_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-input round-robin grant with its priority pointer.
// The pointer moves to the loser only when a grant is taken.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output logic       accept
);

  logic ptr;

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  assign accept = |grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/mem_2_to_1_arbiter.sv
// Round-robin front-end for memory_2_to_1_wrapper.
// One registered op per cycle; read data routed back by tag.
module mem_2_to_1_arbiter
  import mem_2_to_1_arbiter_pkg::*;
#(
  parameter int WIDTH                = 64,
  parameter int SINGLE_MEM_DEPTH     = 7,
  parameter int SINGLE_MEM_DEPTH_LOG = $clog2(SINGLE_MEM_DEPTH),
  parameter int RD_LATENCY           = RD_LATENCY_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_0_valid,
  input  logic                            req_0_we,
  input  logic [SINGLE_MEM_DEPTH_LOG-1:0] req_0_addr,
  input  logic [WIDTH-1:0]                req_0_din,
  output logic                            req_0_ready,
  output logic                            rsp_0_valid,
  output logic [WIDTH-1:0]                rsp_0_dout,
  input  logic                            req_1_valid,
  input  logic                            req_1_we,
  input  logic [SINGLE_MEM_DEPTH_LOG-1:0] req_1_addr,
  input  logic [WIDTH-1:0]                req_1_din,
  output logic                            req_1_ready,
  output logic                            rsp_1_valid,
  output logic [WIDTH-1:0]                rsp_1_dout,
  output logic                            mem_0_wr_en,
  output logic                            mem_0_rd_en,
  output logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_0_wr_addr,
  output logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_0_rd_addr,
  output logic [WIDTH-1:0]                mem_0_din,
  output logic                            mem_1_wr_en,
  output logic                            mem_1_rd_en,
  output logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_1_wr_addr,
  output logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_1_rd_addr,
  output logic [WIDTH-1:0]                mem_1_din,
  input  logic [WIDTH-1:0]                mem_dout
);

  localparam int AW = SINGLE_MEM_DEPTH_LOG;

  typedef struct packed {
    logic             we;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] din;
  } req_t;

  typedef struct packed {
    logic             wr_en;
    logic             rd_en;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] din;
  } side_t;

  req_t       req0;
  req_t       req1;
  req_t       sel;
  logic [1:0] grant;
  logic       accept;
  client_id_t gid;
  side_t      side_d;
  side_t      side0_q;
  side_t      side1_q;

  assign req0 = '{we: req_0_we, addr: req_0_addr, din: req_0_din};
  assign req1 = '{we: req_1_we, addr: req_1_addr, din: req_1_din};

  rr_arbiter_2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({req_1_valid, req_0_valid}),
    .grant  (grant),
    .accept (accept)
  );

  assign req_0_ready = grant[0];
  assign req_1_ready = grant[1];
  assign gid         = grant[1];
  assign sel         = gid ? req1 : req0;

  // Fields the op does not use stay zero on the wrapper bus
  always_comb begin
    side_d         = '0;
    side_d.wr_en   = sel.we;
    side_d.rd_en   = ~sel.we;
    side_d.wr_addr = sel.we ? sel.addr : '0;
    side_d.rd_addr = sel.we ? '0 : sel.addr;
    side_d.din     = sel.we ? sel.din : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      side0_q <= '0;
      side1_q <= '0;
    end else begin
      side0_q <= (accept && !gid) ? side_d : '0;
      side1_q <= (accept && gid) ? side_d : '0;
    end
  end

  assign {mem_0_wr_en, mem_0_rd_en, mem_0_wr_addr,
          mem_0_rd_addr, mem_0_din} = side0_q;
  assign {mem_1_wr_en, mem_1_rd_en, mem_1_wr_addr,
          mem_1_rd_addr, mem_1_din} = side1_q;

  rsp_tag_t         tag_in;
  rsp_tag_t         tag_q [RD_LATENCY];
  rsp_tag_t         tag_out;
  logic [WIDTH-1:0] hold0_q;
  logic [WIDTH-1:0] hold1_q;

  assign tag_in = '{valid: mem_0_rd_en | mem_1_rd_en,
                    id:    mem_1_rd_en};

  // Tag rides alongside the wrapper's read pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_out     = tag_q[RD_LATENCY-1];
  assign rsp_0_valid = tag_out.valid & ~tag_out.id;
  assign rsp_1_valid = tag_out.valid & tag_out.id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold0_q <= '0;
      hold1_q <= '0;
    end else begin
      if (rsp_0_valid) hold0_q <= mem_dout;
      if (rsp_1_valid) hold1_q <= mem_dout;
    end
  end

  assign rsp_0_dout = rsp_0_valid ? mem_dout : hold0_q;
  assign rsp_1_dout = rsp_1_valid ? mem_dout : hold1_q;

endmodule

// File: tb/tb_mem_2_to_1_arbiter.sv
// Bench for mem_2_to_1_arbiter with a wrapper memory model.
// Directed scenarios followed by randomized scoreboard traffic.
module tb_mem_2_to_1_arbiter;

  localparam int W  = 64;
  localparam int D  = 7;
  localparam int AW = 3;
  localparam int RL = 1;
  localparam int N  = 10000;

  typedef struct {
    int           due;
    logic [W-1:0] data;
  } exp_rsp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_0_valid, req_0_we, req_0_ready;
  logic [AW-1:0] req_0_addr;
  logic [W-1:0]  req_0_din, rsp_0_dout;
  logic          rsp_0_valid;
  logic          req_1_valid, req_1_we, req_1_ready;
  logic [AW-1:0] req_1_addr;
  logic [W-1:0]  req_1_din, rsp_1_dout;
  logic          rsp_1_valid;
  logic          mem_0_wr_en, mem_0_rd_en;
  logic [AW-1:0] mem_0_wr_addr, mem_0_rd_addr;
  logic [W-1:0]  mem_0_din;
  logic          mem_1_wr_en, mem_1_rd_en;
  logic [AW-1:0] mem_1_wr_addr, mem_1_rd_addr;
  logic [W-1:0]  mem_1_din;
  logic [W-1:0]  mem_dout;
  logic [143:0]  mem_bus;

  int tests = 0;
  int failed = 0;

  logic [W-1:0] m  [2][8] = '{default: '0};
  logic [W-1:0] gm [2][8] = '{default: '0};
  logic [W-1:0] dpipe [RL];

  always #5 clk = ~clk;

  mem_2_to_1_arbiter #(
    .WIDTH(W), .SINGLE_MEM_DEPTH(D),
    .SINGLE_MEM_DEPTH_LOG(AW), .RD_LATENCY(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0_valid(req_0_valid), .req_0_we(req_0_we),
    .req_0_addr(req_0_addr), .req_0_din(req_0_din),
    .req_0_ready(req_0_ready), .rsp_0_valid(rsp_0_valid),
    .rsp_0_dout(rsp_0_dout),
    .req_1_valid(req_1_valid), .req_1_we(req_1_we),
    .req_1_addr(req_1_addr), .req_1_din(req_1_din),
    .req_1_ready(req_1_ready), .rsp_1_valid(rsp_1_valid),
    .rsp_1_dout(rsp_1_dout),
    .mem_0_wr_en(mem_0_wr_en), .mem_0_rd_en(mem_0_rd_en),
    .mem_0_wr_addr(mem_0_wr_addr), .mem_0_rd_addr(mem_0_rd_addr),
    .mem_0_din(mem_0_din),
    .mem_1_wr_en(mem_1_wr_en), .mem_1_rd_en(mem_1_rd_en),
    .mem_1_wr_addr(mem_1_wr_addr), .mem_1_rd_addr(mem_1_rd_addr),
    .mem_1_din(mem_1_din),
    .mem_dout(mem_dout)
  );

  assign mem_bus = {mem_0_wr_en, mem_0_rd_en, mem_0_wr_addr,
                    mem_0_rd_addr, mem_0_din,
                    mem_1_wr_en, mem_1_rd_en, mem_1_wr_addr,
                    mem_1_rd_addr, mem_1_din};

  // Wrapper stand-in: two regions, registered read, noise when idle
  always @(posedge clk) begin
    if (mem_0_wr_en) m[0][mem_0_wr_addr] <= mem_0_din;
    if (mem_1_wr_en) m[1][mem_1_wr_addr] <= mem_1_din;
    if (mem_0_rd_en) dpipe[0] <= m[0][mem_0_rd_addr];
    else if (mem_1_rd_en) dpipe[0] <= m[1][mem_1_rd_addr];
    else dpipe[0] <= {$urandom, $urandom};
    for (int i = 1; i < RL; i++) dpipe[i] <= dpipe[i-1];
  end

  assign mem_dout = dpipe[RL-1];

  always @(negedge clk) begin
    if (rst_n) begin
      tests++;
      assert ($onehot0({mem_0_wr_en, mem_0_rd_en,
                        mem_1_wr_en, mem_1_rd_en}))
      else begin
        failed++;
        $display("FAIL onehot en=%b required at most one bit",
                 {mem_0_wr_en, mem_0_rd_en,
                  mem_1_wr_en, mem_1_rd_en});
      end
    end
  end

  function automatic logic [143:0] bus(
    input int side, input logic we,
    input logic [AW-1:0] a, input logic [W-1:0] d);
    logic [71:0] s;
    s = {we, ~we, we ? a : {AW{1'b0}}, we ? {AW{1'b0}} : a,
         we ? d : {W{1'b0}}};
    return (side == 0) ? {s, 72'b0} : {72'b0, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_0_valid = 0; req_0_we = 0; req_0_addr = '0; req_0_din = '0;
    req_1_valid = 0; req_1_we = 0; req_1_addr = '0; req_1_din = '0;
  endtask

  task automatic drive(input int c, input logic v, input logic we,
                       input logic [AW-1:0] a, input logic [W-1:0] d);
    if (c == 0) begin
      req_0_valid = v; req_0_we = we; req_0_addr = a; req_0_din = d;
    end else begin
      req_1_valid = v; req_1_we = we; req_1_addr = a; req_1_din = d;
    end
  endtask

  task automatic apply_reset();
    tick();
    idle();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      drive(0, 1'($urandom), 1'($urandom),
            AW'($urandom_range(0, D-1)), {$urandom, $urandom});
      drive(1, 1'($urandom), 1'($urandom),
            AW'($urandom_range(0, D-1)), {$urandom, $urandom});
      #1;
      tests++;
      if (mem_bus !== 144'b0) begin
        failed++;
        $display("FAIL reset_bus got %h required 0", mem_bus);
      end
      tests++;
      if ({rsp_0_valid, rsp_1_valid, rsp_0_dout, rsp_1_dout} !== '0)
      begin
        failed++;
        $display("FAIL reset_rsp got v=%b%b d0=%h d1=%h required 0",
                 rsp_0_valid, rsp_1_valid, rsp_0_dout, rsp_1_dout);
      end
    end
    tick();
    rst_n = 1;
    drive(0, 1, 0, 3'd1, '0);
    drive(1, 1, 0, 3'd1, '0);
    #1;
    tests++;
    if ({req_1_ready, req_0_ready} !== 2'b01) begin
      failed++;
      $display("FAIL reset_first_grant got %b required 01",
               {req_1_ready, req_0_ready});
    end
    tick();
    idle();
    repeat (3) tick();
  endtask

  task automatic test_fill();
    logic [W-1:0] d;
    for (int c = 0; c < 2; c++) begin
      for (int a = 0; a < D; a++) begin
        tick();
        idle();
        d = {$urandom, $urandom};
        drive(c, 1, 1, AW'(a), d);
        gm[c][a] = d;
        #1;
        tests++;
        if ({req_1_ready, req_0_ready} !== (c == 0 ? 2'b01 : 2'b10))
        begin
          failed++;
          $display("FAIL fill_ready c=%0d got %b", c,
                   {req_1_ready, req_0_ready});
        end
      end
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_wr_rd();
    logic [W-1:0] junk;
    junk = {$urandom, $urandom};
    tick(); idle();
    drive(0, 1, 1, 3'd3, 64'hA5);
    gm[0][3] = 64'hA5;
    #1;
    tests++;
    if (req_0_ready !== 1'b1) begin
      failed++;
      $display("FAIL wr_ready got %b required 1", req_0_ready);
    end
    tick(); idle();
    drive(0, 1, 0, 3'd3, junk);
    #1;
    tests++;
    if (mem_bus !== bus(0, 1, 3'd3, 64'hA5)) begin
      failed++;
      $display("FAIL wr_issue got %h required %h",
               mem_bus, bus(0, 1, 3'd3, 64'hA5));
    end
    tick(); idle(); #1;
    tests++;
    if (mem_bus !== bus(0, 0, 3'd3, '0) || rsp_0_valid !== 1'b0)
    begin
      failed++;
      $display("FAIL rd_issue got %h v=%b required %h v=0",
               mem_bus, rsp_0_valid, bus(0, 0, 3'd3, '0));
    end
    tick(); #1;
    tests++;
    if (rsp_0_valid !== 1'b1 || rsp_0_dout !== 64'hA5 ||
        rsp_1_valid !== 1'b0) begin
      failed++;
      $display("FAIL rd_rsp got v=%b%b d=%h required v=10 d=a5",
               rsp_0_valid, rsp_1_valid, rsp_0_dout);
    end
    tick(); #1;
    tests++;
    if (rsp_0_valid !== 1'b0 || rsp_0_dout !== 64'hA5) begin
      failed++;
      $display("FAIL rd_hold got v=%b d=%h required v=0 d=a5",
               rsp_0_valid, rsp_0_dout);
    end
  endtask

  task automatic test_isolation();
    tick(); idle();
    drive(0, 1, 1, 3'd2, 64'h11);
    gm[0][2] = 64'h11;
    #1;
    tests++;
    if (req_0_ready !== 1'b1) begin
      failed++;
      $display("FAIL iso_w0 got %b required 1", req_0_ready);
    end
    tick(); idle();
    drive(1, 1, 1, 3'd2, 64'h22);
    gm[1][2] = 64'h22;
    #1;
    tests++;
    if (req_1_ready !== 1'b1) begin
      failed++;
      $display("FAIL iso_w1 got %b required 1", req_1_ready);
    end
    tick(); idle();
    drive(0, 1, 0, 3'd2, '0);
    drive(1, 1, 0, 3'd2, '0);
    #1;
    tests++;
    if ({req_1_ready, req_0_ready} !== 2'b01) begin
      failed++;
      $display("FAIL iso_grant got %b required 01",
               {req_1_ready, req_0_ready});
    end
    tick(); idle();
    drive(1, 1, 0, 3'd2, '0);
    #1;
    tests++;
    if (req_1_ready !== 1'b1) begin
      failed++;
      $display("FAIL iso_r1 got %b required 1", req_1_ready);
    end
    tick(); idle(); #1;
    tests++;
    if (rsp_0_valid !== 1'b1 || rsp_0_dout !== 64'h11 ||
        rsp_1_valid !== 1'b0) begin
      failed++;
      $display("FAIL iso_rsp0 got v=%b%b d=%h required v=10 d=11",
               rsp_0_valid, rsp_1_valid, rsp_0_dout);
    end
    tick(); #1;
    tests++;
    if (rsp_1_valid !== 1'b1 || rsp_1_dout !== 64'h22 ||
        rsp_0_valid !== 1'b0 || rsp_0_dout !== 64'h11) begin
      failed++;
      $display("FAIL iso_rsp1 got v=%b%b d1=%h d0=%h req 01 22 11",
               rsp_0_valid, rsp_1_valid, rsp_1_dout, rsp_0_dout);
    end
  endtask

  task automatic test_contention();
    int j;
    int c;
    logic [W-1:0] ad;
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      tick(); idle();
      if (k < 6) begin
        drive(0, 1, 0, AW'(k), '0);
        drive(1, 1, 0, AW'(k), '0);
      end
      #1;
      if (k < 6) begin
        tests++;
        if ({req_1_ready, req_0_ready} !==
            ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
          failed++;
          $display("FAIL cont_ready k=%0d got %b", k,
                   {req_1_ready, req_0_ready});
        end
      end
      if (k >= 2) begin
        j = k - 2;
        c = j % 2;
        ad = c ? rsp_1_dout : rsp_0_dout;
        tests++;
        if ({rsp_1_valid, rsp_0_valid} !== (c ? 2'b10 : 2'b01) ||
            ad !== gm[c][j]) begin
          failed++;
          $display("FAIL cont_rsp k=%0d got v=%b d=%h required %h",
                   k, {rsp_1_valid, rsp_0_valid}, ad, gm[c][j]);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    tick(); idle();
    drive(0, 1, 0, 3'd3, '0);
    #1;
    tests++;
    if (req_0_ready !== 1'b1) begin
      failed++;
      $display("FAIL mid_accept got %b required 1", req_0_ready);
    end
    tick(); idle();
    rst_n = 0;
    #1;
    tests++;
    if (mem_bus !== 144'b0) begin
      failed++;
      $display("FAIL mid_bus got %h required 0", mem_bus);
    end
    tick();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      #1;
      tests++;
      if ({rsp_1_valid, rsp_0_valid} !== 2'b00) begin
        failed++;
        $display("FAIL mid_drop i=%0d got %b required 00", i,
                 {rsp_1_valid, rsp_0_valid});
      end
    end
    tick(); idle();
    drive(1, 1, 0, 3'd2, '0);
    tick(); idle();
    tick(); #1;
    tests++;
    if (rsp_1_valid !== 1'b1 || rsp_1_dout !== gm[1][2]) begin
      failed++;
      $display("FAIL mid_after got v=%b d=%h required v=1 d=%h",
               rsp_1_valid, rsp_1_dout, gm[1][2]);
    end
  endtask

  task automatic test_random();
    exp_rsp_t     q0[$];
    exp_rsp_t     q1[$];
    exp_rsp_t     e;
    logic         pv [2];
    logic         pwe [2];
    logic [AW-1:0] pa [2];
    logic [W-1:0] pd [2];
    logic [W-1:0] last [2];
    logic [143:0] exp_bus;
    logic [1:0]   exp_rdy;
    int           pref;
    int           g;
    logic         ev;
    logic [W-1:0] ed;
    logic         av;
    logic [W-1:0] ad;
    apply_reset();
    pv = '{0, 0};
    last = '{'0, '0};
    exp_bus = '0;
    pref = 0;
    for (int k = 0; k < N + 4; k++) begin
      tick();
      tests++;
      if (mem_bus !== exp_bus) begin
        failed++;
        $display("FAIL rnd_bus k=%0d got %h required %h",
                 k, mem_bus, exp_bus);
      end
      for (int c = 0; c < 2; c++) begin
        ev = 0;
        ed = last[c];
        if (c == 0 && q0.size() > 0 && q0[0].due == k) begin
          e = q0.pop_front(); ev = 1; ed = e.data;
        end
        if (c == 1 && q1.size() > 0 && q1[0].due == k) begin
          e = q1.pop_front(); ev = 1; ed = e.data;
        end
        av = c ? rsp_1_valid : rsp_0_valid;
        ad = c ? rsp_1_dout : rsp_0_dout;
        tests++;
        if (av !== ev || ad !== ed) begin
          failed++;
          $display("FAIL rnd_rsp%0d k=%0d got v=%b d=%h req v=%b d=%h",
                   c, k, av, ad, ev, ed);
        end
        last[c] = ed;
      end
      for (int c = 0; c < 2; c++) begin
        if (!pv[c] && k < N && $urandom_range(0, 3) != 0) begin
          pv[c] = 1;
          pwe[c] = 1'($urandom);
          pa[c] = AW'($urandom_range(0, D-1));
          pd[c] = {$urandom, $urandom};
        end
        drive(c, pv[c], pwe[c], pa[c], pd[c]);
      end
      #1;
      if (pv[0] && pv[1]) g = pref;
      else if (pv[0]) g = 0;
      else if (pv[1]) g = 1;
      else g = -1;
      exp_rdy = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
      tests++;
      if ({req_1_ready, req_0_ready} !== exp_rdy) begin
        failed++;
        $display("FAIL rnd_ready k=%0d got %b required %b",
                 k, {req_1_ready, req_0_ready}, exp_rdy);
      end
      exp_bus = '0;
      if (g >= 0) begin
        exp_bus = bus(g, pwe[g], pa[g], pd[g]);
        if (pwe[g]) begin
          gm[g][pa[g]] = pd[g];
        end else begin
          e.due = k + 1 + RL;
          e.data = gm[g][pa[g]];
          if (g == 0) q0.push_back(e);
          else q1.push_back(e);
        end
        pv[g] = 0;
        pref = 1 - g;
      end
    end
    idle();
    tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failed++;
      $display("FAIL rnd_drain got %0d/%0d pending required 0/0",
               q0.size(), q1.size());
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_fill();
    test_wr_rd();
    test_isolation();
    test_contention();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
